// File: rtl/mem_fifo_ctrl_pkg.sv
// mem_fifo_ctrl_pkg: shared sizing for the single-port FIFO and its memory.
package mem_fifo_ctrl_pkg;
    localparam int AW = 6;
    localparam int DW = 8;
    localparam int DEPTH = 1 << AW;
endpackage

// File: rtl/mem_fifo_ctrl_sp_mem.sv
// sp_mem_64x8: single-port synchronous memory, active-low enables, registered read.
module sp_mem_64x8 import mem_fifo_ctrl_pkg::*; (
    input  logic          clk,
    input  logic          ren,
    input  logic          wen,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);
    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!wen) mem[addr] <= din;
        dout <= !ren ? mem[addr] : '0;
    end
endmodule

// File: rtl/mem_fifo_ctrl.sv
// mem_fifo_ctrl: FIFO over one single-port memory; a pending-write register
// lets a simultaneous push and pop both complete at the cost of one bubble.
module mem_fifo_ctrl import mem_fifo_ctrl_pkg::*; (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [DW-1:0] din,
    output logic          push_rdy,
    input  logic          pop,
    output logic          pop_rdy,
    output logic [DW-1:0] dout,
    output logic          valid,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          ovf,
    output logic          udf
);
    logic [AW-1:0] wr_ptr, rd_ptr, addr;
    logic          pend, ren, wen, push_ok, pop_ok;
    logic [DW-1:0] pend_data, mem_din;

    assign full     = count == (AW+1)'(DEPTH);
    assign empty    = count == '0;
    assign push_rdy = !full && !pend;
    assign pop_rdy  = !empty && !pend;
    assign push_ok  = push && push_rdy;
    assign pop_ok   = pop && pop_rdy;

    // Reset forces both enables inactive so the memory output also clears.
    always_comb begin
        wen     = !(reset && (pend || (push_ok && !pop_ok)));
        ren     = !(reset && pop_ok);
        addr    = pend ? wr_ptr : pop_ok ? rd_ptr : push_ok ? wr_ptr : '0;
        addr    = reset ? addr : '0;
        mem_din = pend ? pend_data : din;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            pend      <= 1'b0;
            pend_data <= '0;
            valid     <= 1'b0;
            ovf       <= 1'b0;
            udf       <= 1'b0;
        end else begin
            valid <= pop_ok;
            ovf   <= push && !push_rdy;
            udf   <= pop && !pop_rdy;
            if (pend) begin
                wr_ptr <= wr_ptr + 1'b1;
                pend   <= 1'b0;
            end else if (pop_ok && push_ok) begin
                rd_ptr    <= rd_ptr + 1'b1;
                pend      <= 1'b1;
                pend_data <= din;
            end else if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
                count  <= count - 1'b1;
            end else if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
                count  <= count + 1'b1;
            end
        end
    end

    sp_mem_64x8 u_mem (
        .clk  (clk),
        .ren  (ren),
        .wen  (wen),
        .addr (addr),
        .din  (mem_din),
        .dout (dout)
    );
endmodule

// File: tb/tb_mem_fifo_ctrl.sv
// tb_mem_fifo_ctrl: directed plus randomized checks against a queue-based model.
module tb_mem_fifo_ctrl;
    import mem_fifo_ctrl_pkg::*;

    logic          clk = 1'b0;
    logic          reset, push, pop;
    logic [DW-1:0] din;
    logic          push_rdy, pop_rdy, valid, full, empty, ovf, udf;
    logic [DW-1:0] dout;
    logic [AW:0]   count;

    int checks = 0;
    int errors = 0;

    logic [7:0] q[$];
    bit         bub, m_valid, m_ovf, m_udf;
    logic [7:0] m_dout;

    mem_fifo_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .din      (din),
        .push_rdy (push_rdy),
        .pop      (pop),
        .pop_rdy  (pop_rdy),
        .dout     (dout),
        .valid    (valid),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .ovf      (ovf),
        .udf      (udf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Compare outputs against the model, then apply one cycle of stimulus.
    task automatic cycle(input logic p, input logic [7:0] d, input logic o, input logic r);
        bit m_full, m_empty, m_prdy, m_ordy, pa, oa;
        @(negedge clk);
        m_full  = q.size() == DEPTH;
        m_empty = q.size() == 0;
        m_prdy  = !m_full && !bub;
        m_ordy  = !m_empty && !bub;
        chk("count", 32'(count), 32'(q.size()));
        chk("full", 32'(full), 32'(m_full));
        chk("empty", 32'(empty), 32'(m_empty));
        chk("push_rdy", 32'(push_rdy), 32'(m_prdy));
        chk("pop_rdy", 32'(pop_rdy), 32'(m_ordy));
        chk("valid", 32'(valid), 32'(m_valid));
        chk("dout", 32'(dout), 32'(m_dout));
        chk("ovf", 32'(ovf), 32'(m_ovf));
        chk("udf", 32'(udf), 32'(m_udf));
        push  = p;
        din   = d;
        pop   = o;
        reset = r;
        pa = p && m_prdy;
        oa = o && m_ordy;
        #1;
        if (!r || (!bub && !pa && !oa)) begin
            chk("idle_ren", 32'(dut.ren), 32'd1);
            chk("idle_wen", 32'(dut.wen), 32'd1);
            chk("idle_addr", 32'(dut.addr), 32'd0);
        end
        if (!r) begin
            q.delete();
            bub = 0; m_valid = 0; m_dout = 0; m_ovf = 0; m_udf = 0;
        end else begin
            m_ovf   = p && !m_prdy;
            m_udf   = o && !m_ordy;
            m_valid = oa;
            m_dout  = oa ? q.pop_front() : 8'd0;
            if (pa) q.push_back(d);
            bub = pa && oa;
        end
    endtask

    initial begin
        reset = 1'b0; push = 1'b0; pop = 1'b0; din = '0;
        bub = 0; m_valid = 0; m_dout = 0; m_ovf = 0; m_udf = 0;
        @(negedge clk);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 1);
        foreach (q[i]) ;
        cycle(1, 4, 0, 1); cycle(1, 8, 0, 1); cycle(1, 35, 0, 1); cycle(1, 77, 0, 1);
        repeat (4) cycle(0, 0, 1, 1);
        repeat (2) cycle(0, 0, 0, 1);
        for (int i = 0; i < 64; i++) cycle(1, 8'(i), 0, 1);
        cycle(1, 99, 0, 1);
        cycle(0, 0, 0, 1);
        repeat (64) cycle(0, 0, 1, 1);
        repeat (2) cycle(0, 0, 0, 1);
        cycle(1, 10, 0, 1); cycle(1, 20, 0, 1);
        cycle(1, 30, 1, 1);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 1, 1); cycle(0, 0, 1, 1);
        cycle(0, 0, 0, 1);
        cycle(1, 5, 1, 1);
        cycle(0, 0, 1, 1);
        cycle(0, 0, 0, 1);
        cycle(1, 1, 0, 1); cycle(1, 2, 0, 1); cycle(1, 3, 0, 1);
        cycle(1, 4, 1, 1);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 1);
        repeat (2) cycle(0, 0, 0, 1);
        for (int ph = 0; ph < 3; ph++) begin
            for (int i = 0; i < 1000; i++) begin
                cycle($urandom_range(0, 9) < (ph == 0 ? 8 : ph == 1 ? 2 : 5),
                      8'($urandom),
                      $urandom_range(0, 9) < (ph == 0 ? 2 : ph == 1 ? 8 : 5),
                      $urandom_range(0, 299) != 0);
            end
        end
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
